// File: rtl/instr_fetch.sv
// instr_fetch: BOOT/REQ/EXEC fetch sequencer holding PC, the fetched instruction and a retire counter.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ImemAddr,
  output logic        ImemReq,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        BranchNe,
  input  logic        Zero,
  input  logic        Stall,
  output logic [31:0] Instr,
  output logic [5:0]  InstrOpCode,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] InstrCount
);
  typedef enum logic [1:0] {BOOT, REQ, EXEC} state_t;
  state_t      state_q;
  logic [31:0] pc_q, pc_d, instr_q, count_q, pc4, br_off;
  logic        req_q, valid_q, taken;
  always_comb begin
    pc4    = pc_q + 32'd4;
    br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    taken  = Branch & (Zero ^ BranchNe);
    pc_d   = Jump ? {pc4[31:28], instr_q[25:0], 2'b00} : taken ? pc4 + br_off : pc4;
  end
  // req_q/valid_q are registered alongside the state so they track it exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: if (ImemReady) begin
          instr_q <= ImemData;
          state_q <= EXEC;
          req_q   <= 1'b0;
          valid_q <= 1'b1;
        end
        EXEC: if (!Stall) begin
          pc_q    <= pc_d;
          count_q <= count_q + 32'd1;
          state_q <= REQ;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
  assign ImemAddr    = pc_q;
  assign ImemReq     = req_q;
  assign Instr       = instr_q;
  assign InstrOpCode = instr_q[31:26];
  assign InstrValid  = valid_q;
  assign PC          = pc_q;
  assign PC4         = pc4;
  assign InstrCount  = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random ready/stall traffic against an architectural program-order model with a scoreboard monitor.
module tb_instr_fetch;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic        clk, reset;
  logic [31:0] ImemAddr, ImemData, Instr, PC, PC4, InstrCount;
  logic        ImemReq, ImemReady, Jump, Branch, BranchNe, Zero, Stall, InstrValid;
  logic [5:0]  InstrOpCode;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
    logic        j, b, ne, z;
  } ent_t;
  ent_t exp_q[$];
  int   tests, fails, retired;
  logic rand_en;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .ImemAddr(ImemAddr), .ImemReq(ImemReq),
    .ImemReady(ImemReady), .ImemData(ImemData), .Jump(Jump), .Branch(Branch),
    .BranchNe(BranchNe), .Zero(Zero), .Stall(Stall), .Instr(Instr),
    .InstrOpCode(InstrOpCode), .InstrValid(InstrValid), .PC(PC), .PC4(PC4),
    .InstrCount(InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: a short prologue that branches backwards across address 0, then hashed code.
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] x;
    logic [5:0]  op;
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h1000_FFFD;
    if (a == 32'hFFFF_FFFC) return 32'h2000_0000;
    x = a * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    x = x * 32'h85EB_CA6B;
    x = x ^ (x >> 13);
    case (x[2:0])
      3'd0: op = 6'd2;
      3'd1: op = 6'd3;
      3'd2: op = 6'd4;
      3'd3: op = 6'd5;
      default: op = 6'd8;
    endcase
    return {op, x[31:6]};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Architectural model: instruction k is fetched from the PC produced by retiring k-1.
  task automatic build_q();
    logic [31:0] pc, pc4, i;
    logic [5:0]  op;
    ent_t        e;
    exp_q.delete();
    pc = RPC;
    for (int k = 0; k < 600; k++) begin
      i  = mem(pc);
      op = i[31:26];
      e.pc    = pc;
      e.instr = i;
      e.cnt   = 32'(k);
      e.j     = (op == 6'd2) || (op == 6'd3);
      e.b     = (op == 6'd4) || (op == 6'd5) || (e.j && $urandom_range(0, 1) == 1);
      e.ne    = (op == 6'd5) || (e.j && $urandom_range(0, 1) == 1);
      e.z     = (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      exp_q.push_back(e);
      pc4 = pc + 32'd4;
      if (e.j) pc = {pc4[31:28], i[25:0], 2'b00};
      else if (e.b && (e.z != e.ne)) pc = pc4 + 32'(int'($signed(i[15:0])) * 4);
      else pc = pc4;
    end
  endtask

  initial begin
    {ImemReady, Stall, Jump, Branch, BranchNe, Zero} = '0;
    ImemData = '0;
    forever begin
      @(posedge clk);
      #1;
      Stall     = rand_en ? ($urandom_range(0, 9) < 3) : 1'b0;
      ImemReady = rand_en ? ($urandom_range(0, 9) < 6) : 1'b1;
      ImemData  = (ImemReady && ImemReq) ? mem(ImemAddr) : $urandom;
      if (Stall || exp_q.size() == 0) {Jump, Branch, BranchNe, Zero} = 4'($urandom);
      else {Jump, Branch, BranchNe, Zero} = {exp_q[0].j, exp_q[0].b, exp_q[0].ne, exp_q[0].z};
    end
  end

  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!reset && (ImemReq || InstrValid)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_underflow: got activity expected none");
        end else begin
          e = exp_q[0];
          chk("req_valid_exclusive", 32'(ImemReq && InstrValid), 32'd0);
          if (ImemReq) chk("fetch_addr", ImemAddr, e.pc);
          if (InstrValid) begin
            chk("pc", PC, e.pc);
            chk("pc4", PC4, e.pc + 32'd4);
            chk("instr", Instr, e.instr);
            chk("opcode", 32'(InstrOpCode), 32'(e.instr[31:26]));
            chk("count", InstrCount, e.cnt);
            if (!Stall) begin
              void'(exp_q.pop_front());
              retired++;
            end
          end
        end
      end
    end
  end

  initial begin
    tests = 0; fails = 0; retired = 0;
    rand_en = 1'b0;
    reset = 1'b1;
    build_q();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pc", PC, RPC);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_count", InstrCount, 32'd0);
    chk("rst_req", 32'(ImemReq), 32'd0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("boot_no_req", 32'(ImemReq), 32'd0);
    @(posedge clk); #2;
    chk("first_req", 32'(ImemReq), 32'd1);
    chk("first_addr", ImemAddr, 32'd0);
    @(posedge clk); #2;
    chk("first_valid", 32'(InstrValid), 32'd1);
    chk("first_opcode", 32'(InstrOpCode), 32'h08);
    @(posedge clk); #2;
    chk("second_req", 32'(ImemReq), 32'd1);
    chk("second_addr", ImemAddr, 32'd4);
    chk("count_after_one", InstrCount, 32'd1);
    rand_en = 1'b1;
    for (int c = 0; c < 4000 && retired < 100; c++) @(posedge clk);
    chk("phase1_progress", 32'(retired >= 100), 32'd1);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (ImemReq) break;
    end
    chk("midreq_found", 32'(ImemReq), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_pc", PC, RPC);
    chk("async_req", 32'(ImemReq), 32'd0);
    chk("async_valid", 32'(InstrValid), 32'd0);
    chk("async_instr", Instr, 32'd0);
    chk("async_count", InstrCount, 32'd0);
    build_q();
    retired = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4000 && retired < 100; c++) @(posedge clk);
    chk("phase2_progress", 32'(retired >= 100), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
